operand_fetch: RTL

//  Stage directly downstream of command fetch. Takes a fetched 32-bit command word and the

---
 rtl/operand_fetch_pkg.sv | 52 +++++
 rtl/operand_fetch_if.sv | 22 ++
 rtl/operand_fetch_bus_read_port.sv | 49 ++++
 rtl/operand_fetch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared command-word layout, FSM state codes and decode helper for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned CMD_W          = 32;
  localparam int unsigned CMD_OPC_LSB    = 24;
  localparam int unsigned CMD_OPC_W      = 8;
  localparam int unsigned CMD_DST_LSB    = 20;
  localparam int unsigned CMD_SRC0_LSB   = 16;
  localparam int unsigned CMD_SRC1_LSB   = 12;
  localparam int unsigned CMD_COND_LSB   = 8;
  localparam int unsigned CMD_REG_W      = 4;
  localparam int unsigned CMD_SRC0_IND   = 7;
  localparam int unsigned CMD_SRC1_IND   = 6;
  localparam int unsigned CMD_COND_EN    = 5;

  typedef enum logic [2:0] {
    OPF_IDLE,
    OPF_REQ,
    OPF_S0,
    OPF_S0I,
    OPF_S1,
    OPF_S1I,
    OPF_C,
    OPF_DONE
  } opf_state_e;

  typedef struct packed {
    logic [CMD_OPC_W-1:0] opcode;
    logic [CMD_REG_W-1:0] dst;
    logic [CMD_REG_W-1:0] src0;
    logic [CMD_REG_W-1:0] src1;
    logic [CMD_REG_W-1:0] cond;
    logic                 src0_ind;
    logic                 src1_ind;
    logic                 cond_en;
  } cmd_t;

  // Reserved bits [4:0] are intentionally dropped here.
  function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] c);
    cmd_t d;
    d.opcode   = c[CMD_OPC_LSB  +: CMD_OPC_W];
    d.dst      = c[CMD_DST_LSB  +: CMD_REG_W];
    d.src0     = c[CMD_SRC0_LSB +: CMD_REG_W];
    d.src1     = c[CMD_SRC1_LSB +: CMD_REG_W];
    d.cond     = c[CMD_COND_LSB +: CMD_REG_W];
    d.src0_ind = c[CMD_SRC0_IND];
    d.src1_ind = c[CMD_SRC1_IND];
    d.cond_en  = c[CMD_COND_EN];
    return d;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Register-file read bus between the operand fetch stage (master) and memory (slave).
interface operand_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] addr;
  logic              read_q;
  logic              read_dn;
  logic [DATA_W-1:0] read_data;

  modport master (
    output bus_req, addr, read_q,
    input  bus_gnt, read_dn, read_data
  );

  modport slave (
    input  bus_req, addr, read_q,
    output bus_gnt, read_dn, read_data
  );
endinterface

// File: rtl/operand_fetch_bus_read_port.sv
// Single-read handshake: holds read_q/addr until read_dn, retries on grant loss,
// captures data and pulses ready during the mandatory idle cycle after each read.
module operand_fetch_bus_read_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              bus_gnt,
  input  logic              read_dn,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_q,
  output logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [DATA_W-1:0] data
);

  logic              gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  // Combinational on gnt so a lost grant withdraws the request in the same cycle.
  assign read_q = req & bus_gnt & ~gap_q;
  assign addr   = req ? req_addr : '0;
  assign accept = read_q & read_dn;
  assign ready  = gap_q;
  assign data   = data_q;

  always_comb begin
    gap_d  = accept;
    data_d = data_q;
    if (accept) begin
      data_d = read_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q  <= 1'b0;
      data_q <= '0;
    end else begin
      gap_q  <= gap_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes a command word and reads src0/src1/cond from the
// memory-mapped register file, with optional single-level indirection.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CMD_W-1:0]     command,
  input  logic [ADDR_W-1:0]    base_addr,
  operand_fetch_if.master      bus,
  output logic [CMD_OPC_W-1:0] opcode,
  output logic [CMD_REG_W-1:0] dst_idx,
  output logic [DATA_W-1:0]    src0,
  output logic [DATA_W-1:0]    src1,
  output logic [DATA_W-1:0]    cond,
  output logic                 busy,
  output logic                 done
);

  opf_state_e        state_q, state_d, after_src1;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] src0_q, src0_d, src1_q, src1_d, cond_q, cond_d;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  operand_fetch_bus_read_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_read_port (
    .clk       (clk),
    .rst       (rst),
    .req       (rd_req),
    .req_addr  (rd_addr),
    .bus_gnt   (bus.bus_gnt),
    .read_dn   (bus.read_dn),
    .read_data (bus.read_data),
    .read_q    (bus.read_q),
    .addr      (bus.addr),
    .ready     (rd_ready),
    .data      (rd_data)
  );

  assign after_src1  = cmd_q.cond_en ? OPF_C : OPF_DONE;
  assign busy        = (state_q != OPF_IDLE) && (state_q != OPF_DONE);
  assign done        = (state_q == OPF_DONE);
  assign bus.bus_req = busy;

  assign opcode  = cmd_q.opcode;
  assign dst_idx = cmd_q.dst;
  assign src0    = src0_q;
  assign src1    = src1_q;
  assign cond    = cond_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    base_d  = base_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    cond_d  = cond_q;
    rd_req  = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      OPF_IDLE: begin
        if (start) begin
          state_d = OPF_REQ;
          cmd_d   = decode_cmd(command);
          base_d  = base_addr;
          cond_d  = '0;
        end
      end
      OPF_REQ: begin
        if (bus.bus_gnt) state_d = OPF_S0;
      end
      OPF_S0: begin
        rd_req  = 1'b1;
        rd_addr = base_q + ADDR_W'(cmd_q.src0);
        if (rd_ready) begin
          src0_d  = rd_data;
          state_d = cmd_q.src0_ind ? OPF_S0I : OPF_S1;
        end
      end
      OPF_S0I: begin
        // src0_q holds the pointer fetched in S0.
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(src0_q);
        if (rd_ready) begin
          src0_d  = rd_data;
          state_d = OPF_S1;
        end
      end
      OPF_S1: begin
        rd_req  = 1'b1;
        rd_addr = base_q + ADDR_W'(cmd_q.src1);
        if (rd_ready) begin
          src1_d  = rd_data;
          state_d = cmd_q.src1_ind ? OPF_S1I : after_src1;
        end
      end
      OPF_S1I: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(src1_q);
        if (rd_ready) begin
          src1_d  = rd_data;
          state_d = after_src1;
        end
      end
      OPF_C: begin
        rd_req  = 1'b1;
        rd_addr = base_q + ADDR_W'(cmd_q.cond);
        if (rd_ready) begin
          cond_d  = rd_data;
          state_d = OPF_DONE;
        end
      end
      OPF_DONE: begin
        state_d = OPF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OPF_IDLE;
      cmd_q   <= '0;
      base_q  <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      cond_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      base_q  <= base_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      cond_q  <= cond_d;
    end
  end

endmodule
